// File: rtl/arith_pkg.sv
// Shared types and elaboration helpers for the serial adder/subtractor.
// Used by serial_add_sub (optional feature macro: SERIAL_ADD_SUB_OVF_EN).
package arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    // The slice must tile the operand exactly, otherwise the top slice would be partial.
    function automatic bit slice_divides(input int width, input int slice);
        return (width >= 1) && (slice >= 1) && ((width % slice) == 0);
    endfunction

endpackage

// File: rtl/full_adder_slice.sv
// Combinational ripple of SLICE 1-bit full adders; also exposes the carry into
// the top bit so the caller can derive signed overflow on the MSB slice.
module full_adder_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             ci,
    output logic [SLICE-1:0] s,
    output logic             co,
    output logic             c_msb_in
);

    logic [SLICE:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < SLICE; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
        co       = c[SLICE];
        c_msb_in = c[SLICE-1];
    end

endmodule

// File: rtl/serial_add_sub.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands processed SLICE bits per clock
// through one reused ripple slice. Define SERIAL_ADD_SUB_OVF_EN to add the OVF port.
module serial_add_sub
    import arith_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C0,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] F,
    output logic             C1
`ifdef SERIAL_ADD_SUB_OVF_EN
    ,
    output logic             OVF
`endif
);

    localparam int N     = WIDTH / SLICE;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    if (!slice_divides(WIDTH, SLICE)) begin : g_bad_slice
        $error("serial_add_sub: SLICE must divide WIDTH");
    end

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   bx_reg;
    logic               carry;
    logic [SLICE-1:0]   slice_a;
    logic [SLICE-1:0]   slice_b;
    logic [SLICE-1:0]   slice_s;
    logic               slice_co;
    logic               last_slice;
`ifdef SERIAL_ADD_SUB_OVF_EN
    logic               slice_c_msb_in;
`endif

    always_comb begin
        slice_a    = a_reg[int'(idx)*SLICE +: SLICE];
        slice_b    = bx_reg[int'(idx)*SLICE +: SLICE];
        last_slice = (idx == IDX_W'(N-1));
    end

    full_adder_slice #(.SLICE(SLICE)) u_slice (
        .a        (slice_a),
        .b        (slice_b),
        .ci       (carry),
        .s        (slice_s),
        .co       (slice_co),
`ifdef SERIAL_ADD_SUB_OVF_EN
        .c_msb_in (slice_c_msb_in)
`else
        .c_msb_in ()
`endif
    );

    // Subtraction is A + ~B + ~borrow, so B and C0 are inverted once at accept time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            idx    <= '0;
            a_reg  <= '0;
            bx_reg <= '0;
            carry  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            F      <= '0;
            C1     <= 1'b0;
`ifdef SERIAL_ADD_SUB_OVF_EN
            OVF    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg  <= A;
                        bx_reg <= sub ? ~B : B;
                        carry  <= C0 ^ sub;
                        idx    <= '0;
                        busy   <= 1'b1;
                        state  <= ST_RUN;
                    end else begin
                        state  <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    F[int'(idx)*SLICE +: SLICE] <= slice_s;
                    carry <= slice_co;
                    idx   <= idx + 1'b1;
                    if (last_slice) begin
                        C1    <= slice_co;
`ifdef SERIAL_ADD_SUB_OVF_EN
                        OVF   <= slice_co ^ slice_c_msb_in;
`endif
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
